imem_loader: RTL and testbench

//  Byte-stream program loader: the write side of the core's read-only instruction memory.
//  - Holds the core in reset while it receives a length-prefixed program image over a valid/ready byte port.
//  - Packs bytes little-endian into 32-bit words and writes them sequentially into instruction memory.
//  - Releases the core once the image is complete. Sits beside top, between the host link and inst_mem.

---
 rtl/loader_pkg.sv | 28 ++
 rtl/byte_assembler.sv | 67 ++++++
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loader_pkg
// Purpose  : Shared types and constants for the instruction-memory loader.
//            Loader state encoding, bytes-per-word constant and a helper that
//            says which states take bytes from the host stream.
// Revision : 1.0 - initial release
// ============================================================================
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR0 = 3'd1,
    HDR1 = 3'd2,
    LOAD = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5
  } state_e;

  // States in which the loader raises byte_ready.
  function automatic logic accepts_bytes(input state_e s);
    return (s == HDR0) || (s == HDR1) || (s == LOAD) || (s == CSUM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : byte_assembler
// Purpose  : Packs accepted bytes little-endian into 32-bit words. A 2-bit
//            byte counter tracks position; word_valid_o pulses for one cycle
//            after the 4th byte of a word, with the packed word on word_o.
// Ports    : clk, rst (async, active high)
//            clear_i      - drop any partial word (load start)
//            accept_i     - byte_i is consumed this cycle
//            byte_i       - stream byte
//            last_o       - this accept completes a word (combinational)
//            word_valid_o - packed word ready (registered, 1 cycle)
//            word_o       - packed word {b3,b2,b1,b0}
// Revision : 1.0 - initial release
// ============================================================================
module byte_assembler
  import loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic                        accept_i,
  input  logic [7:0]                  byte_i,
  output logic                        last_o,
  output logic                        word_valid_o,
  output logic [BYTES_PER_WORD*8-1:0] word_o
);

  localparam int WORD_W = BYTES_PER_WORD * 8;

  logic [1:0]        cnt_q,   cnt_d;
  logic [WORD_W-1:0] pack_q,  pack_d;
  logic              valid_q, valid_d;

  always_comb begin
    last_o  = accept_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    valid_d = last_o && !clear_i;
    if (clear_i) begin
      cnt_d  = 2'd0;
      pack_d = '0;
    end else if (accept_i) begin
      cnt_d  = cnt_q + 2'd1;
      // Shift new bytes in from the top: after four bytes the first one
      // received sits in the least significant lane.
      pack_d = {byte_i, pack_q[WORD_W-1:8]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      pack_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      valid_q <= valid_d;
    end
  end

  assign word_valid_o = valid_q;
  assign word_o       = pack_q;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Byte-stream program loader. Holds the core in reset while a
//            length-prefixed image (16-bit LE word count, then 4*N payload
//            bytes) arrives over a valid/ready port, writes the packed words
//            sequentially into instruction memory, then releases the core.
// Config   : LOADER_CHECKSUM_EN - when defined, one trailing checksum byte
//            (XOR of header and payload) is accepted and a mismatch sets
//            load_err. Undefined: no checksum stage.
// Ports    : clk, rst (async, active high)
//            load_start  - begin/restart a load (honoured in IDLE/DONE)
//            byte_valid / byte_data / byte_ready - byte stream handshake
//            imem_we / imem_addr / imem_wdata    - memory write port
//            cpu_rst     - core reset, low only in DONE
//            load_done   - image fully written
//            load_err    - overflow or checksum error, sticky per load
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  load_err
);

  // One extra address bit: when it is set the address has run past the end
  // of memory, and further writes are suppressed.
  localparam logic [ADDR_WIDTH:0] BASE_EXT  = (ADDR_WIDTH + 1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] ADDR_STEP = (ADDR_WIDTH + 1)'(BYTES_PER_WORD);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e PAYLOAD_END = CSUM;
`else
  localparam state_e PAYLOAD_END = DONE;
`endif

  state_e              state_q, state_d;
  logic [15:0]         count_q, count_d;   // word count N from the header
  logic [15:0]         words_q, words_d;   // payload words received
  logic [ADDR_WIDTH:0] addr_q,  addr_d;
  logic                err_q,   err_d;

  logic                accept;
  logic                start;
  logic                overflow;
  logic                asm_last;
  logic                asm_valid;
  logic [31:0]         asm_word;

  assign accept   = byte_valid && byte_ready;
  assign start    = load_start && ((state_q == IDLE) || (state_q == DONE));
  assign overflow = addr_q[ADDR_WIDTH];

  byte_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start),
    .accept_i     (accept && (state_q == LOAD)),
    .byte_i       (byte_data),
    .last_o       (asm_last),
    .word_valid_o (asm_valid),
    .word_o       (asm_word)
  );

  // Next state and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    byte_ready = accepts_bytes(state_q);
    cpu_rst    = (state_q != DONE);
    load_done  = (state_q == DONE);
    case (state_q)
      IDLE: if (load_start) state_d = HDR0;
      HDR0: if (accept) state_d = HDR1;
      HDR1: if (accept) state_d = ({byte_data, count_q[7:0]} != 16'd0) ? LOAD : PAYLOAD_END;
      LOAD: if (asm_last && (words_q == count_q - 16'd1)) state_d = PAYLOAD_END;
      CSUM: if (accept) state_d = DONE;
      DONE: if (load_start) state_d = HDR0;
      default: state_d = IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  // Datapath next-state. The start clause comes last so a restart wins over
  // a write retiring in the same cycle.
  always_comb begin
    count_d = count_q;
    words_d = words_q;
    addr_d  = addr_q;
    err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    if (accept && (state_q != CSUM)) csum_d = csum_q ^ byte_data;
    if (accept && (state_q == CSUM) && (byte_data != csum_q)) err_d = 1'b1;
`endif
    if (accept && (state_q == HDR0)) count_d[7:0]  = byte_data;
    if (accept && (state_q == HDR1)) count_d[15:8] = byte_data;
    if (asm_last) words_d = words_q + 16'd1;
    if (asm_valid) begin
      if (overflow) err_d  = 1'b1;
      else          addr_d = addr_q + ADDR_STEP;
    end
    if (start) begin
      words_d = 16'd0;
      addr_d  = BASE_EXT;
      err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 16'd0;
      words_q <= 16'd0;
      addr_q  <= BASE_EXT;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we    = asm_valid && !overflow;
  assign imem_addr  = addr_q[ADDR_WIDTH-1:0];
  assign imem_wdata = DATA_WIDTH'(asm_word);
  assign load_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader. Two instances share one
//            byte stream: a 4 KiB memory (ADDR_WIDTH=12) and an 8-byte one
//            (ADDR_WIDTH=3) so the same frames exercise the overflow path.
//            Optional checksum stage follows LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;

  logic        rdy_b, we_b, cpurst_b, done_b, err_b;
  logic [11:0] addr_b;
  logic [31:0] wd_b;
  logic        rdy_s, we_s, cpurst_s, done_s, err_s;
  logic [2:0]  addr_s;
  logic [31:0] wd_s;

  always #5 clk = ~clk;

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .BASE_ADDR(0)) dut_big (
    .clk(clk), .rst(rst), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(rdy_b), .imem_we(we_b), .imem_addr(addr_b),
    .imem_wdata(wd_b), .cpu_rst(cpurst_b), .load_done(done_b), .load_err(err_b)
  );

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .BASE_ADDR(0)) dut_small (
    .clk(clk), .rst(rst), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(rdy_s), .imem_we(we_s), .imem_addr(addr_s),
    .imem_wdata(wd_s), .cpu_rst(cpurst_s), .load_done(done_s), .load_err(err_s)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int              n;
    logic [2:0][31:0] w;
    int              gap;
    bit              err_b;
    bit              err_s;
    int              nwr_b;
    int              nwr_s;
  } tv_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  wr_t         got_b[$];
  wr_t         got_s[$];
  logic [31:0] cur_words[$];
  logic [7:0]  csum_acc;
  bit          pulse_mid;
  bit          cur_bad_csum;
  int          gap_max;
  tv_t         tv[5];

  // Write monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (we_b === 1'b1) got_b.push_back({20'b0, addr_b, wd_b});
    if (we_s === 1'b1) got_s.push_back({29'b0, addr_s, wd_s});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int rnd_gap();
    return (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
  endfunction

  // Offer one byte after an optional idle gap; returns one step after the
  // accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    csum_acc   = csum_acc ^ b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy_b === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic start_pulse();
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  // Send a full frame built from cur_words and wait for completion.
  task automatic send_frame();
    int n;
    int lat;
    logic [7:0] cs;
    n = cur_words.size();
    got_b.delete();
    got_s.delete();
    csum_acc = 8'h00;
    start_pulse();
    send_byte(8'(n), rnd_gap());
    send_byte(8'(n >> 8), rnd_gap());
    if (pulse_mid) start_pulse();
    foreach (cur_words[k])
      for (int j = 0; j < 4; j++) send_byte(cur_words[k][8*j +: 8], rnd_gap());
    cs = cur_bad_csum ? ~csum_acc : csum_acc;
    if (CSUM_EN) send_byte(cs, rnd_gap());
    lat = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_b === 1'b1 && done_s === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("done_latency", 64'(lat >= 0 && lat <= 1), 64'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  // Reference: word k goes to byte address 4k if that lies inside memory,
  // otherwise it is dropped and the error flag is raised.
  task automatic check_one(input string tag, input int aw, input wr_t got[$], input logic err);
    wr_t exp[$];
    bit  exp_err;
    exp_err = CSUM_EN && cur_bad_csum;
    foreach (cur_words[k]) begin
      if (4 * k < (1 << aw)) exp.push_back({32'(4 * k), cur_words[k]});
      else exp_err = 1'b1;
    end
    chk({tag, "_nwr"}, 64'(got.size()), 64'(exp.size()));
    foreach (exp[i])
      if (i < got.size()) chk({tag, "_wr"}, got[i], exp[i]);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  task automatic check_frame(input string tag);
    check_one({tag, "_big"}, 12, got_b, err_b);
    check_one({tag, "_small"}, 3, got_s, err_s);
    chk({tag, "_done"}, 64'(done_b & done_s), 64'd1);
    chk({tag, "_cpurst"}, 64'(cpurst_b | cpurst_s), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    tv[0] = '{n:2, w:{32'h0, 32'h00200593, 32'h00100513}, gap:0, err_b:0, err_s:0, nwr_b:2, nwr_s:2};
    tv[1] = '{n:2, w:{32'h0, 32'h00200593, 32'h00100513}, gap:3, err_b:0, err_s:0, nwr_b:2, nwr_s:2};
    tv[2] = '{n:0, w:{32'h0, 32'h0, 32'h0},               gap:1, err_b:0, err_s:0, nwr_b:0, nwr_s:0};
    tv[3] = '{n:1, w:{32'h0, 32'h0, 32'hA5A5_5A5A},       gap:0, err_b:0, err_s:0, nwr_b:1, nwr_s:1};
    tv[4] = '{n:3, w:{32'hCAFE_F00D, 32'h1234_5678, 32'hDEAD_BEEF}, gap:2, err_b:0, err_s:1, nwr_b:3, nwr_s:2};

    rst = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    pulse_mid = 1'b0; cur_bad_csum = 1'b0; gap_max = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_rst", 64'(cpurst_b), 64'd1);
    chk("rst_cpu_rst_small", 64'(cpurst_s), 64'd1);
    chk("rst_load_done", 64'(done_b), 64'd0);
    chk("rst_imem_we", 64'(we_b), 64'd0);
    chk("rst_imem_addr", 64'(addr_b), 64'd0);
    chk("rst_imem_wdata", 64'(wd_b), 64'd0);
    chk("rst_byte_ready", 64'(rdy_b | rdy_s), 64'd0);
    chk("rst_load_err", 64'(err_b), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Bytes offered in IDLE are not consumed.
    byte_valid = 1'b1; byte_data = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready", 64'(rdy_b), 64'd0);
    chk("idle_cpu_rst", 64'(cpurst_b), 64'd1);
    chk("idle_no_write", 64'(got_b.size()), 64'd0);
    byte_valid = 1'b0;

    // Table-driven frames.
    for (int t = 0; t < 5; t++) begin
      cur_words.delete();
      for (int k = 0; k < tv[t].n; k++) cur_words.push_back(tv[t].w[k]);
      gap_max = tv[t].gap;
      send_frame();
      chk("tbl_nwr_big", 64'(got_b.size()), 64'(tv[t].nwr_b));
      chk("tbl_nwr_small", 64'(got_s.size()), 64'(tv[t].nwr_s));
      for (int k = 0; k < got_b.size() && k < 3; k++)
        chk("tbl_wr_big", got_b[k], {32'(4 * k), tv[t].w[k]});
      for (int k = 0; k < got_s.size() && k < 3; k++)
        chk("tbl_wr_small", got_s[k], {32'(4 * k), tv[t].w[k]});
      chk("tbl_err_big", 64'(err_b), 64'(tv[t].err_b));
      chk("tbl_err_small", 64'(err_s), 64'(tv[t].err_s));
      chk("tbl_done", 64'(done_b), 64'd1);
      chk("tbl_cpu_rst", 64'(cpurst_b), 64'd0);
    end

    // DONE ignores stream bytes.
    got_b.delete();
    byte_valid = 1'b1; byte_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    chk("done_hold", 64'(done_b), 64'd1);
    chk("done_no_write", 64'(got_b.size()), 64'd0);

    // Restart from DONE: core reset re-asserted next cycle, error cleared.
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    chk("restart_cpu_rst", 64'(cpurst_b), 64'd1);
    chk("restart_done", 64'(done_b), 64'd0);
    chk("restart_err_clr", 64'(err_s), 64'd0);
    chk("restart_ready", 64'(rdy_b), 64'd1);

    // Reset in the middle of a word.
    got_b.delete(); got_s.delete();
    gap_max = 0;
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h05, 0);
    rst = 1'b1;
    #1;
    chk("midrst_cpu_rst", 64'(cpurst_b), 64'd1);
    chk("midrst_ready", 64'(rdy_b), 64'd0);
    chk("midrst_addr", 64'(addr_b), 64'd0);
    chk("midrst_done", 64'(done_b), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_write", 64'(got_b.size() + got_s.size()), 64'd0);

    cur_words = '{32'h00100513, 32'h00200593};
    send_frame();
    check_frame("after_rst");

    // load_start during a load is ignored.
    pulse_mid = 1'b1;
    cur_words = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
    send_frame();
    pulse_mid = 1'b0;
    check_frame("mid_start");

    // Randomized frames with random valid gaps.
    for (int r = 0; r < 25; r++) begin
      cur_words.delete();
      n = int'($urandom_range(0, 5));
      for (int k = 0; k < n; k++) cur_words.push_back($urandom);
      gap_max = int'($urandom_range(0, 3));
      send_frame();
      check_frame("rand");
    end

    if (CSUM_EN) begin
      cur_bad_csum = 1'b1;
      cur_words = '{32'h00100513};
      gap_max = 0;
      send_frame();
      check_frame("bad_csum");
      cur_bad_csum = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
